max_reduce_seq: RTL and testbench

MAX_REDUCE_SEQ -- requirements
Module: max_reduce_seq

---
 rtl/max_pkg.sv | 13 +
 rtl/max_cmp_sel.sv | 18 +
 rtl/max_reduce_seq.sv | 111 +++++++++++
 tb/tb_max_reduce_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/max_pkg.sv
// Shared types and default sizing for the max_reduce_seq frame reducer.
package max_pkg;

  localparam int unsigned DefWidth    = 8;
  localparam int unsigned DefFrameLen = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } state_e;

endpackage

// File: rtl/max_cmp_sel.sv
// Unsigned compare/select: gt = a > b, sel = larger of the two (b on ties).
module max_cmp_sel
  import max_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic [WIDTH-1:0] sel
);

  always_comb begin
    gt  = (a > b);
    sel = gt ? a : b;
  end

endmodule

// File: rtl/max_reduce_seq.sv
// Streaming per-frame maximum with argmax index and word count.
// Define MAX_REDUCE_INDEX_EN to keep the argmax index register; otherwise out_idx is tied to 0.
module max_reduce_seq
  import max_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned FRAME_LEN = DefFrameLen
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_max,
  output logic [$clog2(FRAME_LEN)-1:0] out_idx,
  output logic [$clog2(FRAME_LEN):0]   out_cnt
);

  localparam int unsigned IDXW = $clog2(FRAME_LEN);
  localparam logic [IDXW:0] FrameLenC = (IDXW + 1)'(FRAME_LEN);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [IDXW:0]    cnt_q, cnt_d;
  logic             accept;
  logic             gt;
  logic [WIDTH-1:0] sel;

  max_cmp_sel #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .a  (in_data),
    .b  (max_q),
    .gt (gt),
    .sel(sel)
  );

  // Handshake depends on state only, so there is no in_* to out_* combinational path.
  always_comb begin
    in_ready  = (state_q != StHold);
    out_valid = (state_q == StHold);
    accept    = in_valid && in_ready;
  end

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          max_d   = in_data;
          cnt_d   = (IDXW + 1)'(1);
          state_d = in_last ? StHold : StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          if (gt) max_d = sel;
          cnt_d = cnt_q + 1'b1;
          if (in_last || (cnt_d == FrameLenC)) state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      max_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_max = max_q;
  assign out_cnt = cnt_q;

`ifdef MAX_REDUCE_INDEX_EN
  logic [IDXW-1:0] idx_q, idx_d;

  // Index of the incoming word equals the count of words already taken.
  always_comb begin
    idx_d = idx_q;
    if (accept) begin
      if (state_q == StIdle) idx_d = '0;
      else if (gt)           idx_d = cnt_q[IDXW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

  assign out_idx = idx_q;
`else
  assign out_idx = '0;
`endif

endmodule

// File: tb/tb_max_reduce_seq.sv
// Scoreboard bench for max_reduce_seq: directed frames plus randomised back-pressure.
module tb_max_reduce_seq;

  localparam int W  = 8;
  localparam int FL = 16;
  localparam int IW = $clog2(FL);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_max;
  logic [IW-1:0] out_idx;
  logic [IW:0]   out_cnt;

  max_reduce_seq #(
    .WIDTH    (W),
    .FRAME_LEN(FL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_max  (out_max),
    .out_idx  (out_idx),
    .out_cnt  (out_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  mx;
    logic [IW-1:0] idx;
    logic [IW:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   ready_pct    = 100;
  int   valid_pct    = 100;
  bit   auto_exp     = 1'b0;

  logic [W-1:0]  m_max;
  logic [IW-1:0] m_idx;
  int            m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] mx, input logic [IW-1:0] idx, input int cnt);
    exp_t e;
    e.mx  = mx;
`ifdef MAX_REDUCE_INDEX_EN
    e.idx = idx;
`else
    e.idx = '0;
`endif
    e.cnt = (IW + 1)'(cnt);
    exp_q.push_back(e);
  endtask

  // Drive one word until accepted; the reference model tracks frame boundaries.
  task automatic send(input logic [W-1:0] d, input logic l);
    logic rdy;
    logic acc;
    while (valid_pct < 100 && $urandom_range(0, 99) >= valid_pct) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    acc      = 1'b0;
    for (int t = 0; t < 500 && !acc; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      acc = rdy;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("accept_timeout", 32'(acc), 32'd1);
    if (!acc) return;
    if (m_cnt == 0) begin
      m_max = d;
      m_idx = '0;
      m_cnt = 1;
    end else begin
      if (d > m_max) begin
        m_max = d;
        m_idx = IW'(m_cnt);
      end
      m_cnt++;
    end
    if (l || m_cnt == FL) begin
      if (auto_exp) push_exp(m_max, m_idx, m_cnt);
      m_cnt = 0;
      @(negedge clk);
      check("latency_out_valid", 32'(out_valid), 32'd1);
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 2000 && exp_q.size() > 0; t++) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    out_ready = ($urandom_range(0, 99) < ready_pct);
  end

  // Monitor: stability and back-pressure while held, scoreboard compare on handshake.
  bit   in_hold = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      check("in_ready_low_in_hold", 32'(in_ready), 32'd0);
      if (in_hold) check("hold_stable", 32'({out_max, out_idx, out_cnt}), 32'(held));
      held    = {out_max, out_idx, out_cnt};
      in_hold = 1'b1;
      if (out_ready) begin
        in_hold = 1'b0;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_result: max=0x%0h idx=%0d cnt=%0d with none expected",
                   out_max, out_idx, out_cnt);
        end else begin
          e = exp_q.pop_front();
          if ({out_max, out_idx, out_cnt} !== e) begin
            tests_failed++;
            $display("FAIL result: got max=0x%0h idx=%0d cnt=%0d, expected max=0x%0h idx=%0d cnt=%0d",
                     out_max, out_idx, out_cnt, e.mx, e.idx, e.cnt);
          end
        end
      end
    end else begin
      in_hold = 1'b0;
    end
  end

  initial begin
    logic [W-1:0] d;
    int           len;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_max", 32'(out_max), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_cnt", 32'(out_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Ties keep the earliest index.
    push_exp(8'd9, 4'd1, 4);
    send(8'd3, 1'b0); send(8'd9, 1'b0); send(8'd9, 1'b0); send(8'd4, 1'b1);

    // Forced close at FRAME_LEN, then a fresh frame.
    push_exp(8'd15, 4'd15, 16);
    for (int i = 0; i < FL; i++) send(W'(i), 1'b0);
    push_exp(8'h42, 4'd0, 1);
    send(8'h42, 1'b1);

    // Unsigned compare across the MSB.
    push_exp(8'hFF, 4'd2, 4);
    send(8'h80, 1'b0); send(8'h7F, 1'b0); send(8'hFF, 1'b0); send(8'hFF, 1'b1);
    wait_drain();

    // Held result under back-pressure.
    ready_pct = 0;
    @(posedge clk);
    #2;
    push_exp(8'hFF, 4'd0, 1);
    send(8'hFF, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("held_out_valid", 32'(out_valid), 32'd1);
    check("held_out_max", 32'(out_max), 32'hFF);
    check("held_out_cnt", 32'(out_cnt), 32'd1);
    ready_pct = 100;
    wait_drain();

    // Reset mid-frame discards the partial result.
    send(8'd5, 1'b0); send(8'd6, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_cnt = 0;
    @(negedge clk);
    check("postrst_out_valid", 32'(out_valid), 32'd0);
    check("postrst_out_cnt", 32'(out_cnt), 32'd0);
    @(posedge clk);
    #1;
    push_exp(8'd7, 4'd0, 2);
    send(8'd7, 1'b0); send(8'd2, 1'b1);

    push_exp(8'd8, 4'd1, 3);
    send(8'd1, 1'b0); send(8'd8, 1'b0); send(8'd3, 1'b1);
    wait_drain();

    // Randomised frames with back-pressure; small value range forces ties.
    auto_exp  = 1'b1;
    ready_pct = 50;
    valid_pct = 70;
    for (int f = 0; f < 1000; f++) begin
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++) begin
        d = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 255));
        send(d, (k == len - 1));
      end
    end
    ready_pct = 100;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
